// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM: streams write data in, or read data out
// with one isolated rden pulse per word so every read sees a fresh rising edge.
module ram_burst_master #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR       = 3'd1,
      RD_PULSE = 3'd2,
      RD_HOLD  = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t            state_r, next_state_s;
   logic [ADDR_W-1:0] cur_addr_r;
   logic [LEN_W-1:0]  count_r;
   logic [DATA_W-1:0] rd_data_r;
   logic              rd_valid_r;
   logic              last_s;
   logic              cmd_ready_s, wr_ready_s, rden_s, busy_s, done_s;
   logic              cmd_ready_r, wr_ready_r, rden_r, busy_r, done_r;

   assign last_s = (count_r == {LEN_W{1'b0}});

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               next_state_s = cmd_we ? WR : RD_PULSE;
            end else begin
               next_state_s = IDLE;
            end
         end
         WR: begin
            if (wr_valid && last_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = WR;
            end
         end
         RD_PULSE: next_state_s = RD_HOLD;
         RD_HOLD: begin
            if (rd_ready) begin
               next_state_s = last_s ? DONE : RD_PULSE;
            end else begin
               next_state_s = RD_HOLD;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Moore outputs decoded from the next state so they can be registered glitch-free
   always_comb begin
      cmd_ready_s = 1'b0;
      wr_ready_s  = 1'b0;
      rden_s      = 1'b0;
      busy_s      = 1'b1;
      done_s      = 1'b0;
      case (next_state_s)
         IDLE: begin
            cmd_ready_s = 1'b1;
            busy_s      = 1'b0;
         end
         WR:       wr_ready_s = 1'b1;
         RD_PULSE: rden_s     = 1'b1;
         RD_HOLD:  busy_s     = 1'b1;
         DONE:     done_s     = 1'b1;
         default: begin
            cmd_ready_s = 1'b0;
            busy_s      = 1'b1;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready_r <= 1'b1;
         wr_ready_r  <= 1'b0;
         rden_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         cmd_ready_r <= cmd_ready_s;
         wr_ready_r  <= wr_ready_s;
         rden_r      <= rden_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   // Address/count bookkeeping and read capture; the last word never advances cur_addr
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr_r <= {ADDR_W{1'b0}};
         count_r    <= {LEN_W{1'b0}};
         rd_data_r  <= {DATA_W{1'b0}};
         rd_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  cur_addr_r <= cmd_addr;
                  count_r    <= cmd_len;
               end
            end
            WR: begin
               if (wr_valid && !last_s) begin
                  cur_addr_r <= cur_addr_r + ADDR_W'(1);
                  count_r    <= count_r - LEN_W'(1);
               end
            end
            RD_PULSE: begin
               rd_data_r  <= ram_q;
               rd_valid_r <= 1'b1;
            end
            RD_HOLD: begin
               if (rd_ready) begin
                  rd_valid_r <= 1'b0;
                  if (!last_s) begin
                     cur_addr_r <= cur_addr_r + ADDR_W'(1);
                     count_r    <= count_r - LEN_W'(1);
                  end
               end
            end
            default: begin
               rd_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_r;
   assign wr_ready    = wr_ready_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign rd_data     = rd_data_r;
   assign rd_valid    = rd_valid_r;
   assign ram_rden    = rden_r;
   assign ram_address = cur_addr_r;
   assign ram_data    = wr_data;
   assign ram_wren    = wr_ready_r & wr_valid;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: behavioural RAM, word-level reference
// memory, table-driven bursts, hand-written corner sequences and random bursts.
module tb_ram_burst_master;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [11:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [13:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [13:0] rd_data;
   logic        rd_valid, rd_ready;
   logic        busy, done;
   logic [13:0] ram_data;
   logic [11:0] ram_address;
   logic        ram_wren, ram_rden;
   logic [13:0] ram_q;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int rden_cnt = 0;
   logic prev_rden = 1'b0;

   bit   [13:0] mem     [4096];
   bit   [13:0] ref_mem [4096];
   logic [13:0] wdat    [256];
   logic [13:0] got     [$];

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  len;
      logic [13:0] seed;
      logic [11:0] exp_end;
   } vec_t;
   vec_t vt [5];

   ram_burst_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .done(done),
      .ram_data(ram_data), .ram_address(ram_address),
      .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: write on clk edge, q refreshed on rising rden
   always @(posedge clk) if (ram_wren) mem[ram_address] <= ram_data;
   always @(posedge ram_rden) begin
      #1;
      ram_q = mem[ram_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Strobe monitor
   always @(negedge clk) begin
      if (ram_rden) begin
         rden_cnt++;
         check("rden_single_cycle", {31'd0, prev_rden}, 32'd0);
      end
      if (ram_wren) check("wren_only_in_wr", {31'd0, wr_ready}, 32'd1);
      if (done) done_cnt++;
      prev_rden = ram_rden;
   end

   task automatic start_cmd(input logic we, input logic [11:0] a, input logic [7:0] len);
      int t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready_timeout", t, (t < 50) ? t : 0);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("busy_after_cmd", {31'd0, busy}, 32'd1);
      check("cmd_ready_after_cmd", {31'd0, cmd_ready}, 32'd0);
   endtask

   task automatic do_write(input logic [11:0] a, input logic [7:0] len, input int max_gap);
      logic [11:0] ad;
      start_cmd(1'b1, a, len);
      for (int i = 0; i <= int'(len); i++) begin
         int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         ad = a + 12'(i);
         for (int g = 0; g < gap; g++) begin
            wr_valid = 1'b0;
            #1;
            check("wr_stall_wren", {31'd0, ram_wren}, 32'd0);
            check("wr_stall_ready", {31'd0, wr_ready}, 32'd1);
            @(negedge clk);
         end
         wr_valid = 1'b1;
         wr_data  = wdat[i];
         #1;
         check("wr_wren", {31'd0, ram_wren}, 32'd1);
         check("wr_addr", {20'd0, ram_address}, {20'd0, ad});
         check("wr_data", {18'd0, ram_data}, {18'd0, wdat[i]});
         ref_mem[ad] = wdat[i];
         @(negedge clk);
      end
      wr_valid = 1'b0;
      check("wr_done", {31'd0, done}, 32'd1);
      check("wr_done_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("wr_done_pulse", {31'd0, done}, 32'd0);
      check("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);
      check("wr_end_addr", {20'd0, ram_address}, {20'd0, a + 12'(len)});
   endtask

   task automatic do_read(input logic [11:0] a, input logic [7:0] len, input int first_bp, input int max_bp);
      logic [11:0] ad;
      int bp;
      got.delete();
      start_cmd(1'b0, a, len);
      for (int i = 0; i <= int'(len); i++) begin
         ad = a + 12'(i);
         check("rd_pulse_rden", {31'd0, ram_rden}, 32'd1);
         check("rd_pulse_addr", {20'd0, ram_address}, {20'd0, ad});
         check("rd_pulse_valid", {31'd0, rd_valid}, 32'd0);
         @(negedge clk);
         check("rd_hold_valid", {31'd0, rd_valid}, 32'd1);
         check("rd_hold_data", {18'd0, rd_data}, {18'd0, ref_mem[ad]});
         check("rd_hold_rden", {31'd0, ram_rden}, 32'd0);
         got.push_back(rd_data);
         bp = (i == 0) ? first_bp : ((max_bp > 0) ? int'($urandom_range(max_bp, 0)) : 0);
         for (int k = 0; k < bp; k++) begin
            rd_ready = 1'b0;
            @(negedge clk);
            check("bp_valid", {31'd0, rd_valid}, 32'd1);
            check("bp_data", {18'd0, rd_data}, {18'd0, ref_mem[ad]});
            check("bp_rden", {31'd0, ram_rden}, 32'd0);
            check("bp_addr", {20'd0, ram_address}, {20'd0, ad});
         end
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
      end
      check("rd_done", {31'd0, done}, 32'd1);
      check("rd_done_valid", {31'd0, rd_valid}, 32'd0);
      @(negedge clk);
      check("rd_done_pulse", {31'd0, done}, 32'd0);
      check("rd_idle_ready", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0;
      vt[0] = '{12'h010, 8'd2,  14'h0100, 12'h012};
      vt[1] = '{12'hFFF, 8'd1,  14'h0200, 12'h000};
      vt[2] = '{12'hFFE, 8'd3,  14'h3FF0, 12'h001};
      vt[3] = '{12'h000, 8'd0,  14'h1555, 12'h000};
      vt[4] = '{12'h7F0, 8'd15, 14'h2000, 12'h7FF};

      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 12'h000; cmd_len = 8'd0;
      wr_data = 14'h0000; wr_valid = 1'b0; rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_rd_data", {18'd0, rd_data}, 32'd0);
      check("rst_rden", {31'd0, ram_rden}, 32'd0);
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      check("rst_addr", {20'd0, ram_address}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Write then read back
      wdat[0] = 14'h1234; wdat[1] = 14'h0ABC; wdat[2] = 14'h3FFF;
      d0 = done_cnt;
      do_write(12'h010, 8'd2, 0);
      check("t1_wr_done_count", done_cnt - d0, 1);
      d0 = done_cnt; r0 = rden_cnt;
      do_read(12'h010, 8'd2, 0, 0);
      check("t1_rd_done_count", done_cnt - d0, 1);
      check("t1_rden_pulses", rden_cnt - r0, 3);
      check("t1_word0", {18'd0, got[0]}, 32'h1234);
      check("t1_word1", {18'd0, got[1]}, 32'h0ABC);
      check("t1_word2", {18'd0, got[2]}, 32'h3FFF);

      // Read backpressure: 5 cycles held on the first word
      do_read(12'h010, 8'd1, 5, 0);
      check("bp_word0", {18'd0, got[0]}, 32'h1234);
      check("bp_word1", {18'd0, got[1]}, 32'h0ABC);

      // Wrap-around
      wdat[0] = 14'h0001; wdat[1] = 14'h0002;
      do_write(12'hFFF, 8'd1, 0);
      check("wrap_mem_fff", {18'd0, mem[12'hFFF]}, 32'h0001);
      check("wrap_mem_000", {18'd0, mem[12'h000]}, 32'h0002);

      // Write stall with a command pulsed while busy
      start_cmd(1'b1, 12'h200, 8'd0);
      d0 = done_cnt;
      for (int g = 0; g < 4; g++) begin
         wr_valid = 1'b0;
         #1;
         check("stall_wren", {31'd0, ram_wren}, 32'd0);
         if (g == 1) begin
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 12'h555; cmd_len = 8'd3;
         end
         if (g == 2) begin
            check("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("busy_still_wr", {31'd0, wr_ready}, 32'd1);
            check("busy_addr", {20'd0, ram_address}, 32'h200);
            check("busy_rden", {31'd0, ram_rden}, 32'd0);
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      wr_valid = 1'b1; wr_data = 14'h2AAA;
      #1;
      check("stall_hs_wren", {31'd0, ram_wren}, 32'd1);
      ref_mem[12'h200] = 14'h2AAA;
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      check("stall_post_wren", {31'd0, ram_wren}, 32'd0);
      check("stall_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      check("stall_done_count", done_cnt - d0, 1);
      check("stall_mem", {18'd0, mem[12'h200]}, 32'h2AAA);

      // Table-driven write/readback bursts
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i <= int'(vt[v].len); i++) wdat[i] = vt[v].seed + 14'(i * 37);
         do_write(vt[v].addr, vt[v].len, 1);
         do_read(vt[v].addr, vt[v].len, 0, 1);
         check("vec_end_addr", {20'd0, ram_address}, {20'd0, vt[v].exp_end});
         for (int i = 0; i <= int'(vt[v].len); i++)
            check("vec_word", {18'd0, got[i]}, {18'd0, vt[v].seed + 14'(i * 37)});
      end

      // Reset during the third RD_HOLD of a long read
      for (int i = 0; i < 8; i++) wdat[i] = 14'h0A00 + 14'(i);
      do_write(12'h300, 8'd7, 0);
      start_cmd(1'b0, 12'h300, 8'd7);
      d0 = done_cnt;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_burst_data", {18'd0, rd_data}, {18'd0, 14'h0A00 + 14'(i)});
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
      end
      @(negedge clk);
      check("rst_third_hold", {31'd0, rd_valid}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("midrst_rden", {31'd0, ram_rden}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("midrst_no_done", done_cnt - d0, 0);
      do_read(12'h302, 8'd0, 0, 0);
      check("midrst_readback", {18'd0, got[0]}, 32'h0A02);

      // Random bursts against the reference memory
      for (int n = 0; n < 30; n++) begin
         logic        we;
         logic [11:0] a;
         logic [7:0]  len;
         we  = 1'($urandom_range(1, 0));
         a   = 12'($urandom);
         len = 8'($urandom_range(4, 0));
         if (we) begin
            for (int i = 0; i <= int'(len); i++) wdat[i] = 14'($urandom);
            do_write(a, len, 2);
         end else begin
            do_read(a, len, int'($urandom_range(2, 0)), 2);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
